// File: rtl/reciprocal_nr_seq_if.sv
// Request/result bundle for the sequential Newton-Raphson reciprocal unit.
interface reciprocal_nr_seq_if;
  logic        start;
  logic [15:0] din;
  logic        busy;
  logic        done;
  logic [23:0] dout;
  logic        dz;
  logic [3:0]  iter_cnt;

  modport master (output start, din, input busy, done, dout, dz, iter_cnt);
  modport slave  (input start, din, output busy, done, dout, dz, iter_cnt);
endinterface

// File: rtl/reciprocal_nr_seq.sv
// Multi-cycle 1/x for a 16-bit unsigned integer, result in unsigned [4:-19].
// One shared 24x24 multiplier and one 24-bit subtractor are stepped by the FSM.
module reciprocal_nr_seq #(
  parameter int unsigned MAX_ITER = 8
) (
  input  logic               clk,
  input  logic               rst,
  reciprocal_nr_seq_if.slave bus
);

  localparam logic [23:0] C_A    = 24'h0F0F0D;
  localparam logic [23:0] C_B    = 24'h169696;
  localparam logic [23:0] C_HALF = 24'h040000;
  localparam logic [23:0] C_TWO  = 24'h100000;
  localparam logic [3:0]  C_MAX  = 4'(MAX_ITER);

  typedef enum logic [3:0] {
    IDLE, SCALE, MUL_A, SUB_B, MUL_SCALED, SUB_2, MUL_NEW, CHECK_EQ, ASSIGN_NEW, DENORM
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [23:0] r_s;
  logic [23:0] r_x;
  logic [23:0] r_t;
  logic [4:0]  r_sh;
  logic [3:0]  r_cnt;
  logic [23:0] r_dout;
  logic        r_dz;
  logic [3:0]  r_iter;
  logic        r_done;

  logic [23:0] w_mul_a;
  logic [23:0] w_mul_b;
  logic [47:0] w_prod;
  logic [23:0] w_mul_res;
  logic [23:0] w_sub_a;
  logic [23:0] w_sub_b;
  logic [23:0] w_diff;
  logic        w_unused;

  assign w_prod    = w_mul_a * w_mul_b;
  assign w_mul_res = w_prod[42:19];
  assign w_unused  = ^{w_prod[47:43], w_prod[18:0]};
  assign w_diff    = w_sub_a - w_sub_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state plus operand steering for the shared multiplier/subtractor.
  always_comb begin
    w_state_nxt = r_state;
    w_mul_a     = r_x;
    w_mul_b     = r_t;
    w_sub_a     = C_TWO;
    w_sub_b     = r_t;
    case (r_state)
      IDLE:       if (bus.start && (bus.din != 16'd0)) w_state_nxt = SCALE;
      SCALE:      if (r_s >= C_HALF) w_state_nxt = MUL_A;
      MUL_A: begin
        w_mul_a     = r_s;
        w_mul_b     = C_A;
        w_state_nxt = SUB_B;
      end
      SUB_B: begin
        w_sub_a     = C_B;
        w_sub_b     = r_x;
        w_state_nxt = MUL_SCALED;
      end
      MUL_SCALED: begin
        w_mul_a     = r_x;
        w_mul_b     = r_s;
        w_state_nxt = SUB_2;
      end
      SUB_2:      w_state_nxt = MUL_NEW;
      MUL_NEW:    w_state_nxt = CHECK_EQ;
      CHECK_EQ:   w_state_nxt = ((r_t == r_x) || (r_cnt >= C_MAX)) ? DENORM : ASSIGN_NEW;
      ASSIGN_NEW: w_state_nxt = MUL_SCALED;
      DENORM:     w_state_nxt = IDLE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s    <= '0;
      r_x    <= '0;
      r_t    <= '0;
      r_sh   <= '0;
      r_cnt  <= '0;
      r_dout <= '0;
      r_dz   <= 1'b0;
      r_iter <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            if (bus.din == 16'd0) begin
              r_dout <= '1;
              r_dz   <= 1'b1;
              r_iter <= '0;
              r_done <= 1'b1;
            end else begin
              r_s   <= {8'b0, bus.din};
              r_sh  <= 5'd19;
              r_cnt <= '0;
            end
          end
        end
        SCALE: begin
          if (r_s < C_HALF) begin
            r_s  <= r_s << 1;
            r_sh <= r_sh - 5'd1;
          end
        end
        MUL_A:      r_x <= w_mul_res;
        SUB_B:      r_x <= w_diff;
        MUL_SCALED: r_t <= w_mul_res;
        SUB_2:      r_t <= w_diff;
        MUL_NEW: begin
          r_t   <= w_mul_res;
          r_cnt <= r_cnt + 4'd1;
        end
        ASSIGN_NEW: r_x <= r_t;
        DENORM: begin
          // X approximates 2^19/S with S = din<<n, so undoing the scaling is X>>(19-n).
          r_dout <= r_x >> r_sh;
          r_dz   <= 1'b0;
          r_iter <= r_cnt;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (r_state != IDLE);
  assign bus.done     = r_done;
  assign bus.dout     = r_dout;
  assign bus.dz       = r_dz;
  assign bus.iter_cnt = r_iter;

endmodule
